// File: rtl/avm_host_if.sv
// Command/response port and Avalon-MM agent bus of avm_host.
// The master modport is the host side; slave is the command source plus agent side.
interface avm_host_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_address;
  logic [31:0]           cmd_writedata;
  logic [3:0]            cmd_byteenable;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_readdata;
  logic [1:0]            rsp_response;
  logic                  rsp_timeout;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] avm_m0_address;
  logic                  avm_m0_read;
  logic                  avm_m0_write;
  logic [3:0]            avm_m0_byteenable;
  logic [31:0]           avm_m0_writedata;
  logic                  avm_m0_waitrequest;
  logic                  avm_m0_readdatavalid;
  logic                  avm_m0_writeresponsevalid;
  logic [31:0]           avm_m0_readdata;
  logic [1:0]            avm_m0_response;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_writedata, cmd_byteenable, rsp_ready,
           avm_m0_waitrequest, avm_m0_readdatavalid, avm_m0_writeresponsevalid,
           avm_m0_readdata, avm_m0_response,
    output cmd_ready, rsp_valid, rsp_readdata, rsp_response, rsp_timeout, busy,
           avm_m0_address, avm_m0_read, avm_m0_write, avm_m0_byteenable, avm_m0_writedata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_writedata, cmd_byteenable, rsp_ready,
           avm_m0_waitrequest, avm_m0_readdatavalid, avm_m0_writeresponsevalid,
           avm_m0_readdata, avm_m0_response,
    input  cmd_ready, rsp_valid, rsp_readdata, rsp_response, rsp_timeout, busy,
           avm_m0_address, avm_m0_read, avm_m0_write, avm_m0_byteenable, avm_m0_writedata
  );
endinterface

// File: rtl/avm_host.sv
// Avalon-MM host: one command in, one read/write transfer out, one response back,
// single transaction outstanding, guarded by a watchdog.
module avm_host #(
  parameter int ADDR_WIDTH         = 12,
  parameter int TIMEOUT_CYCLES     = 255,
  parameter int USE_WRITE_RESPONSE = 1
) (
  input  logic        clk,
  input  logic        rst,
  avm_host_if.master  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RSP  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  is_write_q, is_write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_readdata_q, rsp_readdata_d;
  logic [1:0]            rsp_response_q, rsp_response_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  timeout_hit;

  // The counter saturates at the limit so a late acceptance cannot wrap it past the check.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LIMIT);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    is_write_d     = is_write_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    be_d           = be_q;
    read_d         = read_q;
    write_d        = write_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_readdata_d = rsp_readdata_q;
    rsp_response_d = rsp_response_q;
    rsp_timeout_d  = rsp_timeout_q;
    if (state_q == REQ || state_q == RSP) begin
      cnt_d = (cnt_q == TO_LIMIT) ? cnt_q : cnt_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d    = REQ;
          cnt_d      = '0;
          is_write_d = bus.cmd_write;
          addr_d     = bus.cmd_address & ADDR_MASK;
          wdata_d    = bus.cmd_writedata;
          be_d       = bus.cmd_write ? bus.cmd_byteenable : 4'hF;
          read_d     = !bus.cmd_write;
          write_d    = bus.cmd_write;
        end
      end
      REQ: begin
        if (!bus.avm_m0_waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (is_write_q && USE_WRITE_RESPONSE == 0) begin
            state_d        = DONE;
            rsp_valid_d    = 1'b1;
            rsp_readdata_d = '0;
            rsp_response_d = 2'b00;
            rsp_timeout_d  = 1'b0;
          end else begin
            state_d = RSP;
          end
        end else if (timeout_hit) begin
          read_d         = 1'b0;
          write_d        = 1'b0;
          state_d        = DONE;
          rsp_valid_d    = 1'b1;
          rsp_readdata_d = '0;
          rsp_response_d = 2'b11;
          rsp_timeout_d  = 1'b1;
        end
      end
      RSP: begin
        if (!is_write_q && bus.avm_m0_readdatavalid) begin
          state_d        = DONE;
          rsp_valid_d    = 1'b1;
          rsp_readdata_d = bus.avm_m0_readdata;
          rsp_response_d = bus.avm_m0_response;
          rsp_timeout_d  = 1'b0;
        end else if (is_write_q && bus.avm_m0_writeresponsevalid) begin
          state_d        = DONE;
          rsp_valid_d    = 1'b1;
          rsp_readdata_d = '0;
          rsp_response_d = bus.avm_m0_response;
          rsp_timeout_d  = 1'b0;
        end else if (timeout_hit) begin
          state_d        = DONE;
          rsp_valid_d    = 1'b1;
          rsp_readdata_d = '0;
          rsp_response_d = 2'b11;
          rsp_timeout_d  = 1'b1;
        end
      end
      default: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      is_write_q     <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      be_q           <= '0;
      read_q         <= 1'b0;
      write_q        <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_readdata_q <= '0;
      rsp_response_q <= 2'b00;
      rsp_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      is_write_q     <= is_write_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      be_q           <= be_d;
      read_q         <= read_d;
      write_q        <= write_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_readdata_q <= rsp_readdata_d;
      rsp_response_q <= rsp_response_d;
      rsp_timeout_q  <= rsp_timeout_d;
    end
  end

  assign bus.cmd_ready         = (state_q == IDLE);
  assign bus.busy              = (state_q != IDLE);
  assign bus.avm_m0_address    = addr_q;
  assign bus.avm_m0_read       = read_q;
  assign bus.avm_m0_write      = write_q;
  assign bus.avm_m0_byteenable = be_q;
  assign bus.avm_m0_writedata  = wdata_q;
  assign bus.rsp_valid         = rsp_valid_q;
  assign bus.rsp_readdata      = rsp_readdata_q;
  assign bus.rsp_response      = rsp_response_q;
  assign bus.rsp_timeout       = rsp_timeout_q;
endmodule

// File: tb/tb_avm_host.sv
// Directed bench for avm_host: bus is TIMEOUT_CYCLES=8 with write responses,
// bus2 completes writes on acceptance.
module tb_avm_host;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  avm_host_if #(.ADDR_WIDTH(12)) bus ();
  avm_host_if #(.ADDR_WIDTH(12)) bus2 ();

  avm_host #(.ADDR_WIDTH(12), .TIMEOUT_CYCLES(8), .USE_WRITE_RESPONSE(1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  avm_host #(.ADDR_WIDTH(12), .TIMEOUT_CYCLES(8), .USE_WRITE_RESPONSE(0)) dut_nr (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready got %b exp 1", bus.cmd_ready); else n_pass++;
    n_checks++; if ({bus.rsp_valid, bus.avm_m0_read, bus.avm_m0_write, bus.busy, bus.rsp_timeout} !== 5'b0)
      $display("FAIL rst_ctrl got %b exp 00000", {bus.rsp_valid, bus.avm_m0_read, bus.avm_m0_write, bus.busy, bus.rsp_timeout});
    else n_pass++;
    n_checks++; if ({bus.avm_m0_address, bus.avm_m0_byteenable, bus.rsp_readdata, bus.rsp_response} !== '0)
      $display("FAIL rst_data got %h/%h/%h/%h exp 0", bus.avm_m0_address, bus.avm_m0_byteenable, bus.rsp_readdata, bus.rsp_response);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_read();
    step();
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_address = 12'h004;
    bus.cmd_byteenable = 4'h3; bus.avm_m0_waitrequest = 1'b0;
    step();
    bus.cmd_valid = 1'b0;
    n_checks++; if ({bus.avm_m0_read, bus.avm_m0_write, bus.cmd_ready, bus.busy} !== 4'b1001)
      $display("FAIL rd_strobe got %b exp 1001", {bus.avm_m0_read, bus.avm_m0_write, bus.cmd_ready, bus.busy});
    else n_pass++;
    n_checks++; if (bus.avm_m0_address !== 12'h004 || bus.avm_m0_byteenable !== 4'hF)
      $display("FAIL rd_addr_be got %h/%h exp 004/f", bus.avm_m0_address, bus.avm_m0_byteenable);
    else n_pass++;
    step();
    n_checks++; if (bus.avm_m0_read !== 1'b0 || bus.rsp_valid !== 1'b0)
      $display("FAIL rd_pulse got rd=%b vld=%b exp 0/0", bus.avm_m0_read, bus.rsp_valid);
    else n_pass++;
    bus.avm_m0_readdatavalid = 1'b1; bus.avm_m0_readdata = 32'hDEADBEEF; bus.avm_m0_response = 2'b00;
    step();
    bus.avm_m0_readdatavalid = 1'b0; bus.avm_m0_readdata = '0;
    n_checks++; if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_response} !== 4'b1000 || bus.rsp_readdata !== 32'hDEADBEEF)
      $display("FAIL rd_rsp got %b/%b/%b %h exp 1/0/00 deadbeef", bus.rsp_valid, bus.rsp_timeout, bus.rsp_response, bus.rsp_readdata);
    else n_pass++;
    handshake();
    n_checks++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1)
      $display("FAIL rd_hs got vld=%b rdy=%b exp 0/1", bus.rsp_valid, bus.cmd_ready);
    else n_pass++;
  endtask

  task automatic test_write_wait();
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_address = 12'h008;
    bus.cmd_writedata = 32'h000000A5; bus.cmd_byteenable = 4'b0001; bus.avm_m0_waitrequest = 1'b1;
    step();
    bus.cmd_valid = 1'b0; bus.cmd_writedata = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.avm_m0_write !== 1'b1 || bus.avm_m0_writedata !== 32'hA5 ||
                      bus.avm_m0_byteenable !== 4'b0001 || bus.avm_m0_address !== 12'h008)
        $display("FAIL wr_hold%0d got %b %h %h %h exp 1 a5 1 008", i, bus.avm_m0_write,
                 bus.avm_m0_writedata, bus.avm_m0_byteenable, bus.avm_m0_address);
      else n_pass++;
      if (i == 3) bus.avm_m0_waitrequest = 1'b0;
      step();
    end
    n_checks++; if (bus.avm_m0_write !== 1'b0) $display("FAIL wr_drop got %b exp 0", bus.avm_m0_write); else n_pass++;
    bus.avm_m0_readdatavalid = 1'b1; bus.avm_m0_readdata = 32'h00001234;
    step();
    bus.avm_m0_readdatavalid = 1'b0; bus.avm_m0_readdata = '0;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL wr_ign_rdv got %b exp 0", bus.rsp_valid); else n_pass++;
    bus.avm_m0_writeresponsevalid = 1'b1; bus.avm_m0_response = 2'b10;
    step();
    bus.avm_m0_writeresponsevalid = 1'b0; bus.avm_m0_response = 2'b00;
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_response !== 2'b10 || bus.rsp_readdata !== 32'h0 || bus.rsp_timeout !== 1'b0)
      $display("FAIL wr_rsp got %b %b %h %b exp 1 10 0 0", bus.rsp_valid, bus.rsp_response, bus.rsp_readdata, bus.rsp_timeout);
    else n_pass++;
    handshake();
  endtask

  task automatic test_addr_align();
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_address = 12'h00F;
    step();
    bus.cmd_valid = 1'b0;
    n_checks++; if (bus.avm_m0_address !== 12'h00C) $display("FAIL addr_align got %h exp 00c", bus.avm_m0_address); else n_pass++;
    step();
    bus.avm_m0_readdatavalid = 1'b1; bus.avm_m0_readdata = 32'h0BADF00D; bus.avm_m0_response = 2'b01;
    step();
    bus.avm_m0_readdatavalid = 1'b0; bus.avm_m0_response = 2'b00;
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_response !== 2'b01 || bus.rsp_readdata !== 32'h0BADF00D)
      $display("FAIL align_rsp got %b %b %h exp 1 01 0badf00d", bus.rsp_valid, bus.rsp_response, bus.rsp_readdata);
    else n_pass++;
    handshake();
  endtask

  task automatic test_timeout();
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_address = 12'h010;
    bus.cmd_writedata = 32'h55; bus.cmd_byteenable = 4'hF; bus.avm_m0_waitrequest = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      n_checks++; if (bus.avm_m0_write !== 1'b1 || bus.rsp_valid !== 1'b0)
        $display("FAIL to_stall%0d got wr=%b vld=%b exp 1/0", i, bus.avm_m0_write, bus.rsp_valid);
      else n_pass++;
      step();
    end
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL to_early got %b exp 0", bus.rsp_valid); else n_pass++;
    step();
    n_checks++; if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_response, bus.avm_m0_write} !== 5'b11110 || bus.rsp_readdata !== 32'h0)
      $display("FAIL to_rsp got %b %h exp 11110 0", {bus.rsp_valid, bus.rsp_timeout, bus.rsp_response, bus.avm_m0_write}, bus.rsp_readdata);
    else n_pass++;
    bus.avm_m0_writeresponsevalid = 1'b1; bus.avm_m0_response = 2'b00;
    step();
    n_checks++; if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_response} !== 4'b1111)
      $display("FAIL to_late_done got %b exp 1111", {bus.rsp_valid, bus.rsp_timeout, bus.rsp_response});
    else n_pass++;
    handshake();
    step();
    n_checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1)
      $display("FAIL to_late_idle got vld=%b busy=%b rdy=%b exp 0/0/1", bus.rsp_valid, bus.busy, bus.cmd_ready);
    else n_pass++;
    bus.avm_m0_writeresponsevalid = 1'b0; bus.avm_m0_waitrequest = 1'b0;
  endtask

  task automatic test_backpressure();
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_address = 12'h020;
    step();
    bus.cmd_valid = 1'b0;
    step();
    bus.avm_m0_readdatavalid = 1'b1; bus.avm_m0_readdata = 32'hCAFE0001;
    step();
    bus.avm_m0_readdatavalid = 1'b0; bus.avm_m0_readdata = '0;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_address = 12'h030; bus.cmd_writedata = 32'h77;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_response, bus.cmd_ready, bus.avm_m0_write, bus.avm_m0_read} !== 7'b1000000 ||
                      bus.rsp_readdata !== 32'hCAFE0001)
        $display("FAIL bp_hold%0d got %b %h exp 1000000 cafe0001", i,
                 {bus.rsp_valid, bus.rsp_timeout, bus.rsp_response, bus.cmd_ready, bus.avm_m0_write, bus.avm_m0_read}, bus.rsp_readdata);
      else n_pass++;
      step();
    end
    handshake();
    n_checks++; if (bus.cmd_ready !== 1'b1 || bus.avm_m0_write !== 1'b0 || bus.rsp_valid !== 1'b0)
      $display("FAIL bp_release got rdy=%b wr=%b vld=%b exp 1/0/0", bus.cmd_ready, bus.avm_m0_write, bus.rsp_valid);
    else n_pass++;
    step();
    bus.cmd_valid = 1'b0;
    n_checks++; if (bus.avm_m0_write !== 1'b1 || bus.avm_m0_address !== 12'h030)
      $display("FAIL bp_next got wr=%b addr=%h exp 1/030", bus.avm_m0_write, bus.avm_m0_address);
    else n_pass++;
    step();
    bus.avm_m0_writeresponsevalid = 1'b1;
    step();
    bus.avm_m0_writeresponsevalid = 1'b0;
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_response !== 2'b00 || bus.rsp_readdata !== 32'h0)
      $display("FAIL bp_next_rsp got %b %b %h exp 1 00 0", bus.rsp_valid, bus.rsp_response, bus.rsp_readdata);
    else n_pass++;
    handshake();
  endtask

  task automatic test_no_wr_resp();
    bus2.cmd_valid = 1'b1; bus2.cmd_write = 1'b1; bus2.cmd_address = 12'h008;
    bus2.cmd_writedata = 32'h5A; bus2.cmd_byteenable = 4'h2;
    bus2.avm_m0_waitrequest = 1'b0; bus2.avm_m0_response = 2'b10;
    step();
    bus2.cmd_valid = 1'b0;
    n_checks++; if (bus2.avm_m0_write !== 1'b1 || bus2.rsp_valid !== 1'b0)
      $display("FAIL nr_strobe got wr=%b vld=%b exp 1/0", bus2.avm_m0_write, bus2.rsp_valid);
    else n_pass++;
    step();
    n_checks++; if ({bus2.avm_m0_write, bus2.rsp_valid, bus2.rsp_response, bus2.rsp_timeout} !== 5'b01000 || bus2.rsp_readdata !== 32'h0)
      $display("FAIL nr_rsp got %b %h exp 01000 0", {bus2.avm_m0_write, bus2.rsp_valid, bus2.rsp_response, bus2.rsp_timeout}, bus2.rsp_readdata);
    else n_pass++;
    bus2.rsp_ready = 1'b1;
    step();
    bus2.rsp_ready = 1'b0;
    n_checks++; if (bus2.cmd_ready !== 1'b1 || bus2.rsp_valid !== 1'b0)
      $display("FAIL nr_hs got rdy=%b vld=%b exp 1/0", bus2.cmd_ready, bus2.rsp_valid);
    else n_pass++;
  endtask

  task automatic test_rst_mid();
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_address = 12'h040;
    bus.cmd_writedata = 32'hFFFF0000; bus.avm_m0_waitrequest = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({bus.avm_m0_read, bus.busy, bus.cmd_ready} !== 3'b001 || bus.avm_m0_address !== 12'h0)
      $display("FAIL rst_req got %b %h exp 001 000", {bus.avm_m0_read, bus.busy, bus.cmd_ready}, bus.avm_m0_address);
    else n_pass++;
    rst = 1'b0;
    bus.avm_m0_waitrequest = 1'b0;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    step();
    n_checks++; if (bus.busy !== 1'b1 || bus.avm_m0_read !== 1'b0 || bus.rsp_valid !== 1'b0)
      $display("FAIL rst_in_rsp got busy=%b rd=%b vld=%b exp 1/0/0", bus.busy, bus.avm_m0_read, bus.rsp_valid);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({bus.cmd_ready, bus.busy, bus.rsp_valid, bus.avm_m0_read, bus.avm_m0_write} !== 5'b10000 ||
                    bus.avm_m0_address !== 12'h0 || bus.avm_m0_byteenable !== 4'h0 || bus.avm_m0_writedata !== 32'h0)
      $display("FAIL rst_rsp got %b %h %h %h exp 10000 0 0 0", {bus.cmd_ready, bus.busy, bus.rsp_valid, bus.avm_m0_read, bus.avm_m0_write},
               bus.avm_m0_address, bus.avm_m0_byteenable, bus.avm_m0_writedata);
    else n_pass++;
    rst = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_address = 12'h044;
    step();
    bus.cmd_valid = 1'b0;
    n_checks++; if (bus.avm_m0_read !== 1'b1 || bus.avm_m0_address !== 12'h044)
      $display("FAIL post_rst_rd got rd=%b addr=%h exp 1/044", bus.avm_m0_read, bus.avm_m0_address);
    else n_pass++;
    step();
    bus.avm_m0_readdatavalid = 1'b1; bus.avm_m0_readdata = 32'h13579BDF;
    step();
    bus.avm_m0_readdatavalid = 1'b0;
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_readdata !== 32'h13579BDF || bus.rsp_response !== 2'b00)
      $display("FAIL post_rst_rsp got %b %h %b exp 1 13579bdf 00", bus.rsp_valid, bus.rsp_readdata, bus.rsp_response);
    else n_pass++;
    handshake();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_address = '0; bus.cmd_writedata = '0;
    bus.cmd_byteenable = '0; bus.rsp_ready = 1'b0; bus.avm_m0_waitrequest = 1'b0;
    bus.avm_m0_readdatavalid = 1'b0; bus.avm_m0_writeresponsevalid = 1'b0;
    bus.avm_m0_readdata = '0; bus.avm_m0_response = '0;
    bus2.cmd_valid = 1'b0; bus2.cmd_write = 1'b0; bus2.cmd_address = '0; bus2.cmd_writedata = '0;
    bus2.cmd_byteenable = '0; bus2.rsp_ready = 1'b0; bus2.avm_m0_waitrequest = 1'b0;
    bus2.avm_m0_readdatavalid = 1'b0; bus2.avm_m0_writeresponsevalid = 1'b0;
    bus2.avm_m0_readdata = '0; bus2.avm_m0_response = '0;
    test_reset();
    test_read();
    test_write_wait();
    test_addr_align();
    test_timeout();
    test_backpressure();
    test_no_wr_resp();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
